// File: rtl/min_max_pkg.sv
// min_max_pkg: command encoding and error-injection codes shared by the
// LED-bar decoder and its output register.
package min_max_pkg;

  // LED rendering command
  typedef enum logic [1:0] {
    COM_WINDOW = 2'b00,
    COM_LINEAR = 2'b01,
    COM_OFF    = 2'b10,
    COM_ON     = 2'b11
  } com_t;

  // Error-injection selectors (only honoured with MIN_MAX_ERR_INJECT_EN)
  localparam int ERR_NONE       = 0;
  localparam int ERR_WIN_NO_OSC = 1;  // window mode ignores osc_i
  localparam int ERR_LIN_SHORT  = 2;  // linear mode drops LED val_i
  localparam int ERR_ON_BIT0    = 3;  // on mode clears bit 0
  localparam int ERR_WIN_MIN_GT = 4;  // window check uses val_i > min_i
  localparam int ERR_NO_RESET   = 5;  // reset has no effect

endpackage

// File: rtl/min_max_decode.sv
// min_max_decode: purely combinational next-LED-vector computation.
// Optional macro MIN_MAX_ERR_INJECT_EN compiles in the ERRNO-selected defects;
// without it ERRNO has no effect on the logic.
module min_max_decode
  import min_max_pkg::*;
#(
  parameter int VALSIZE = 4,
  parameter int ERRNO   = 0
) (
  input  logic [1:0]            com_i,
  input  logic [VALSIZE-1:0]    min_i,
  input  logic [VALSIZE-1:0]    max_i,
  input  logic [VALSIZE-1:0]    val_i,
  input  logic                  osc_i,
  output logic [2**VALSIZE-1:0] leds_o
);

`ifdef MIN_MAX_ERR_INJECT_EN
  localparam bit ERR_WIN_NO_OSC_EN = (ERRNO == ERR_WIN_NO_OSC);
  localparam bit ERR_LIN_SHORT_EN  = (ERRNO == ERR_LIN_SHORT);
  localparam bit ERR_ON_BIT0_EN    = (ERRNO == ERR_ON_BIT0);
  localparam bit ERR_WIN_MIN_GT_EN = (ERRNO == ERR_WIN_MIN_GT);
`else
  // Injection disabled: flags are tied to zero regardless of ERRNO
  localparam bit ERR_WIN_NO_OSC_EN = (ERRNO == ERR_WIN_NO_OSC) && 1'b0;
  localparam bit ERR_LIN_SHORT_EN  = (ERRNO == ERR_LIN_SHORT)  && 1'b0;
  localparam bit ERR_ON_BIT0_EN    = (ERRNO == ERR_ON_BIT0)    && 1'b0;
  localparam bit ERR_WIN_MIN_GT_EN = (ERRNO == ERR_WIN_MIN_GT) && 1'b0;
`endif

  logic               win_ok;
  logic               blink;
  logic [VALSIZE-1:0] idx;

  // Build the LED vector bit by bit; all comparisons are unsigned at VALSIZE width
  always_comb begin
    leds_o = '0;
    idx    = '0;
    blink  = ERR_WIN_NO_OSC_EN ? 1'b0 : osc_i;
    if (ERR_WIN_MIN_GT_EN) begin
      win_ok = (val_i > min_i) && (val_i <= max_i);
    end else begin
      win_ok = (val_i >= min_i) && (val_i <= max_i);
    end
    for (int i = 0; i < 2**VALSIZE; i++) begin
      idx = i[VALSIZE-1:0];
      case (com_t'(com_i))
        COM_WINDOW: begin
          if (win_ok) begin
            if ((idx >= min_i) && (idx <= val_i)) begin
              leds_o[i] = 1'b1;
            end else if ((idx > val_i) && (idx <= max_i)) begin
              leds_o[i] = blink;
            end
          end
        end
        COM_LINEAR: begin
          if (ERR_LIN_SHORT_EN) begin
            leds_o[i] = (idx < val_i);
          end else begin
            leds_o[i] = (idx <= val_i);
          end
        end
        COM_OFF: leds_o[i] = 1'b0;
        COM_ON: begin
          leds_o[i] = !(ERR_ON_BIT0_EN && (i == 0));
        end
        default: leds_o[i] = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/min_max_top.sv
// min_max_top: registered LED-bar driver. One cycle of latency from inputs to
// leds_o, synchronous active-high reset. There is no handshake: every edge
// samples whatever is on the inputs. Optional macro MIN_MAX_ERR_INJECT_EN
// enables the ERRNO-selected defects (including ignoring reset).
module min_max_top
  import min_max_pkg::*;
#(
  parameter int VALSIZE = 4,
  parameter int ERRNO   = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            com_i,
  input  logic [VALSIZE-1:0]    max_i,
  input  logic [VALSIZE-1:0]    min_i,
  input  logic                  osc_i,
  input  logic [VALSIZE-1:0]    val_i,
  output logic [2**VALSIZE-1:0] leds_o
);

`ifdef MIN_MAX_ERR_INJECT_EN
  localparam bit ERR_NO_RESET_EN = (ERRNO == ERR_NO_RESET);
`else
  localparam bit ERR_NO_RESET_EN = (ERRNO == ERR_NO_RESET) && 1'b0;
`endif

  logic [2**VALSIZE-1:0] leds_d;
  logic [2**VALSIZE-1:0] leds_q;

  min_max_decode #(
    .VALSIZE (VALSIZE),
    .ERRNO   (ERRNO)
  ) u_decode (
    .com_i  (com_i),
    .min_i  (min_i),
    .max_i  (max_i),
    .val_i  (val_i),
    .osc_i  (osc_i),
    .leds_o (leds_d)
  );

  // Output register; reset clears the LEDs on the edge it is seen
  always_ff @(posedge clk_i) begin
    if (rst_i && !ERR_NO_RESET_EN) begin
      leds_q <= '0;
    end else begin
      leds_q <= leds_d;
    end
  end

  assign leds_o = leds_q;

endmodule

// File: tb/tb_min_max_top.sv
// tb_min_max_top: directed table-driven bench for min_max_top (VALSIZE=4).
module tb_min_max_top;

  localparam int VALSIZE = 4;
  localparam int NL      = 2**VALSIZE;

  typedef struct {
    string          name;
    logic [1:0]     com;
    logic [3:0]     min;
    logic [3:0]     max;
    logic [3:0]     val;
    logic           osc;
    logic [NL-1:0]  exp;
  } vec_t;

  logic          clk;
  logic          rst;
  logic [1:0]    com;
  logic [3:0]    max_v;
  logic [3:0]    min_v;
  logic          osc;
  logic [3:0]    val;
  logic [NL-1:0] leds;

  int checks = 0;
  int errors = 0;

  min_max_top #(
    .VALSIZE (VALSIZE),
    .ERRNO   (0)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .com_i  (com),
    .max_i  (max_v),
    .min_i  (min_v),
    .osc_i  (osc),
    .val_i  (val),
    .leds_o (leds)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare the LED output against an expected value
  task automatic check(input string name, input logic [NL-1:0] exp);
    checks++;
    if (leds !== exp) begin
      errors++;
      $display("FAIL %s: leds_o=0x%04h expected 0x%04h", name, leds, exp);
    end
  endtask

  task automatic drive(input logic [1:0] c, input logic [3:0] mn,
                       input logic [3:0] mx, input logic [3:0] v, input logic o);
    com = c; min_v = mn; max_v = mx; val = v; osc = o;
  endtask

  // One edge, then sample 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"win",         2'b00, 4'd3, 4'd8, 4'd5,  1'b0, 16'h0038});
    vecs.push_back('{"win_blink",   2'b00, 4'd3, 4'd8, 4'd5,  1'b1, 16'h01F8});
    vecs.push_back('{"win_outside", 2'b00, 4'd3, 4'd8, 4'd9,  1'b1, 16'h0000});
    vecs.push_back('{"win_below",   2'b00, 4'd3, 4'd8, 4'd2,  1'b1, 16'h0000});
    vecs.push_back('{"win_invert",  2'b00, 4'd8, 4'd3, 4'd5,  1'b1, 16'h0000});
    vecs.push_back('{"win_single0", 2'b00, 4'd0, 4'd0, 4'd0,  1'b1, 16'h0001});
    vecs.push_back('{"win_single4", 2'b00, 4'd4, 4'd4, 4'd4,  1'b1, 16'h0010});
    vecs.push_back('{"win_val_max", 2'b00, 4'd2, 4'd6, 4'd6,  1'b1, 16'h007C});
    vecs.push_back('{"win_val_min", 2'b00, 4'd2, 4'd6, 4'd2,  1'b1, 16'h007C});
    vecs.push_back('{"win_full",    2'b00, 4'd0, 4'd15,4'd15, 1'b0, 16'hFFFF});
    vecs.push_back('{"lin5",        2'b01, 4'd9, 4'd1, 4'd5,  1'b0, 16'h003F});
    vecs.push_back('{"lin15",       2'b01, 4'd0, 4'd0, 4'd15, 1'b1, 16'hFFFF});
    vecs.push_back('{"lin0",        2'b01, 4'd3, 4'd8, 4'd0,  1'b1, 16'h0001});
    vecs.push_back('{"off",         2'b10, 4'd0, 4'd15,4'd7,  1'b1, 16'h0000});
    vecs.push_back('{"on",          2'b11, 4'd8, 4'd3, 4'd0,  1'b0, 16'hFFFF});

    // Reset held for two edges with com=on
    rst = 1'b1;
    drive(2'b11, 4'd0, 4'd0, 4'd0, 1'b0);
    step();
    check("reset_edge1", 16'h0000);
    step();
    check("reset_edge2", 16'h0000);
    rst = 1'b0;
    step();
    check("reset_release", 16'hFFFF);

    // Table-driven vectors, each checked one edge after it is applied
    foreach (vecs[k]) begin
      drive(vecs[k].com, vecs[k].min, vecs[k].max, vecs[k].val, vecs[k].osc);
      step();
      check(vecs[k].name, vecs[k].exp);
    end

    // Latency: toggle off/on every cycle; output lags by exactly one edge
    drive(2'b10, 4'd0, 4'd0, 4'd0, 1'b0);
    step();
    check("lat_init", 16'h0000);
    for (int c = 0; c < 8; c++) begin
      logic [NL-1:0] prev;
      logic [NL-1:0] want;
      prev = (com == 2'b11) ? 16'hFFFF : 16'h0000;
      com  = (com == 2'b11) ? 2'b10 : 2'b11;
      want = (com == 2'b11) ? 16'hFFFF : 16'h0000;
      check("lat_hold", prev);
      step();
      check("lat_update", want);
    end

    // Blink delay: osc change only shows after the next edge
    drive(2'b00, 4'd3, 4'd8, 4'd5, 1'b0);
    step();
    check("osc_low", 16'h0038);
    osc = 1'b1;
    #2;
    check("osc_not_yet", 16'h0038);
    step();
    check("osc_high", 16'h01F8);

    // Reset mid-operation clears on that edge, then recovers
    drive(2'b11, 4'd0, 4'd0, 4'd0, 1'b0);
    step();
    check("mid_on", 16'hFFFF);
    rst = 1'b1;
    step();
    check("mid_reset", 16'h0000);
    rst = 1'b0;
    step();
    check("mid_recover", 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/min_max_top.md
# min_max_top

Registered LED-bar driver that renders a value against a configurable min/max window on a 2**VALSIZE-wide LED vector. A 2-bit command selects windowed display, linear thermometer, all-off or all-on. Values above the current value, up to max, blink with an external oscillator input. It sits between the board's switch/register inputs and the LED outputs, and also serves as the verification target for error-injection exercises.

## Interface
- VALSIZE, default 4: width of min/max/value; legal range 2..8.
- ERRNO, default 0: error-injection selector; 0 gives correct behaviour.
- clk_i  in  1: single clock; all state on the rising edge.
- rst_i  in  1: synchronous reset, active-high.
- com_i  in  2: command; 00 window, 01 linear, 10 off, 11 on.
- max_i  in  VALSIZE: upper window bound, unsigned.
- min_i  in  VALSIZE: lower window bound, unsigned.
- osc_i  in  1: blink level for LEDs above value in window mode.
- val_i  in  VALSIZE: current value, unsigned.
- leds_o  out  2**VALSIZE: LED vector, bit i is LED i.

## Operation
- The next LED vector N is computed combinationally from the inputs and all bits default to 0:
  - com=00 (window): if min_i <= val_i <= max_i, then N[i]=1 for min_i <= i <= val_i, and N[i]=osc_i for val_i < i <= max_i. Otherwise N=0.
  - com=01 (linear): N[i]=1 for 0 <= i <= val_i. min_i, max_i and osc_i are ignored.
  - com=10 (off): N=0.
  - com=11 (on): N is all ones.
- All comparisons are unsigned at VALSIZE width, with no wrap-around.
- min_i > max_i: the window condition can never hold, so com=00 gives N=0.
- min_i = max_i = val_i: only LED val_i is lit.
- val_i = max_i: there is no blinking region.
- val_i = 2**VALSIZE-1 with com=01 gives all ones.

## Timing
- leds_o is a register: leds_o <= N on every rising clk_i edge.
- Latency is 1 cycle: inputs sampled at edge k appear on leds_o after edge k.
- There is no handshake; inputs may change every cycle.
- Reset: when rst_i=1 at an edge, leds_o <= 0, overriding all inputs.
  - Reset mid-operation clears the LEDs on that edge.
  - The first valid output appears one edge after rst_i is released.
- osc_i is sampled like the other inputs, so the visible blink is delayed by 1 cycle.
- There is no other internal state.

## Configuration
- Macro MIN_MAX_ERR_INJECT_EN.
- Defined: ERRNO selects one injected defect. Any ERRNO value not listed behaves correctly.
  - 1: window mode ignores osc_i (region above val_i is always 0).
  - 2: linear mode lights 0..val_i-1, so LED val_i is off.
  - 3: on mode forces bit 0 to 0.
  - 4: window check uses val_i > min_i, so val_i = min_i gives 0.
  - 5: reset is ignored.
- Undefined: no injection logic is compiled and ERRNO is ignored.

## Structure
- Package min_max_pkg holds:
  - com_t enum: COM_WINDOW=2'b00, COM_LINEAR=2'b01, COM_OFF=2'b10, COM_ON=2'b11.
  - ERRNO code constants.
- Sub-module min_max_decode, purely combinational: (com, min, max, val, osc) -> N, including the error-injection hooks.
- min_max_top holds only the output register and the reset.

## Test plan
All scenarios use VALSIZE=4 and ERRNO=0; results are checked one edge after the inputs are applied.
- Reset: rst_i=1 for 2 cycles with com=11 -> leds_o=0x0000. After release -> 0xFFFF.
- Window: com=00, min=3, max=8, val=5, osc=0 -> 0x0038.
- Window blink: same inputs with osc=1 -> 0x01F8.
- Window outside range: com=00, min=3, max=8, val=9 -> 0x0000.
- Window with inverted bounds: min=8, max=3, val=5 -> 0x0000.
- Window single LED: min=max=val=0 -> 0x0001.
- Linear: com=01, val=5 -> 0x003F. With val=15 -> 0xFFFF. With val=0 -> 0x0001.
- Off/on: com=10 -> 0x0000. com=11 -> 0xFFFF.
- Latency: toggle com 10/11 every cycle -> leds_o alternates 0x0000/0xFFFF, lagging the inputs by exactly 1 cycle.
